// File: rtl/sgen_phase_ctrl_if.sv
// Bundle between the phase controller, its CORDIC core and the downstream sample consumer.
// master: the controller; slave: the surrounding core/consumer side.
interface sgen_phase_ctrl_if #(
    parameter int unsigned gp_phase_width = 16,
    parameter int unsigned gp_z_width     = 8,
    parameter int unsigned gp_xy_width    = 8
);
    logic                      i_ena;
    logic [gp_phase_width-1:0] i_fcw;
    logic                      i_ready;
    logic                      o_cordic_ena;
    logic [gp_xy_width-1:0]    o_cordic_x;
    logic [gp_xy_width-1:0]    o_cordic_y;
    logic [gp_z_width-1:0]     o_cordic_z;
    logic [gp_xy_width-1:0]    i_cordic_x;
    logic [gp_xy_width-1:0]    i_cordic_y;
    logic [gp_xy_width-1:0]    o_cos;
    logic [gp_xy_width-1:0]    o_sin;
    logic                      o_valid;

    modport master (
        input  i_ena, i_fcw, i_ready, i_cordic_x, i_cordic_y,
        output o_cordic_ena, o_cordic_x, o_cordic_y, o_cordic_z, o_cos, o_sin, o_valid
    );

    modport slave (
        output i_ena, i_fcw, i_ready, i_cordic_x, i_cordic_y,
        input  o_cordic_ena, o_cordic_x, o_cordic_y, o_cordic_z, o_cos, o_sin, o_valid
    );
endinterface

// File: rtl/sgen_phase_ctrl.sv
// Phase accumulator, quadrant fold and result correction around an iterative CORDIC core.
// Define SGEN_PHASE_DITHER_EN to add LFSR dither to the phase before truncation.
module sgen_phase_ctrl #(
    parameter int unsigned gp_phase_width = 16,
    parameter int unsigned gp_z_width     = 8,
    parameter int unsigned gp_xy_width    = 8,
    parameter int unsigned gp_nr_iter     = 16,
    parameter int unsigned gp_x_init      = 77
) (
    input  logic              i_clk,
    input  logic              i_rst,
    sgen_phase_ctrl_if.master bus
);
    localparam int unsigned lp_cnt_width = $clog2(gp_nr_iter + 1);
    localparam logic [gp_z_width-1:0]  lp_z_half  = {1'b1, {(gp_z_width-1){1'b0}}};
    localparam logic [gp_xy_width-1:0] lp_xy_min  = {1'b1, {(gp_xy_width-1){1'b0}}};
    localparam logic [gp_xy_width-1:0] lp_xy_max  = {1'b0, {(gp_xy_width-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, ISSUE, RUN, OUT} state_t;

    state_t                    state_q, state_d;
    logic [gp_phase_width-1:0] acc_q, acc_d;
    logic [lp_cnt_width-1:0]   cnt_q, cnt_d;
    logic                      neg_q, neg_d;
    logic                      cordic_ena_q, cordic_ena_d;
    logic [gp_xy_width-1:0]    cordic_x_q, cordic_x_d;
    logic [gp_xy_width-1:0]    cordic_y_q, cordic_y_d;
    logic [gp_z_width-1:0]     cordic_z_q, cordic_z_d;
    logic [gp_xy_width-1:0]    cos_q, cos_d;
    logic [gp_xy_width-1:0]    sin_q, sin_d;
    logic                      valid_q, valid_d;

    logic [gp_z_width-1:0]     p_c;
    logic                      fold_c;

`ifdef SGEN_PHASE_DITHER_EN
    localparam int unsigned lp_dith_width = gp_phase_width - gp_z_width;
    logic [15:0]               lfsr_q, lfsr_d;
    logic [gp_phase_width-1:0] dith_sum_c;

    // Dither only perturbs the truncation; the accumulator itself stays exact.
    assign dith_sum_c = acc_q + gp_phase_width'(lfsr_q[lp_dith_width-1:0]);
    assign p_c        = dith_sum_c[gp_phase_width-1 -: gp_z_width];
`else
    assign p_c        = acc_q[gp_phase_width-1 -: gp_z_width];
`endif

    // Quadrants 1 and 2 are rotated by pi into [-pi/2, pi/2); the result is negated later.
    assign fold_c = p_c[gp_z_width-1] ^ p_c[gp_z_width-2];

    function automatic logic [gp_xy_width-1:0] neg_sat(input logic [gp_xy_width-1:0] v);
        if (v == lp_xy_min) return lp_xy_max;
        return gp_xy_width'(0) - v;
    endfunction

    // Next-state and next-register values.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        neg_d        = neg_q;
        cordic_ena_d = cordic_ena_q;
        cordic_x_d   = cordic_x_q;
        cordic_y_d   = cordic_y_q;
        cordic_z_d   = cordic_z_q;
        cos_d        = cos_q;
        sin_d        = sin_q;
        valid_d      = valid_q;
`ifdef SGEN_PHASE_DITHER_EN
        lfsr_d       = lfsr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.i_ena) state_d = ISSUE;
            end
            ISSUE: begin
                cordic_z_d   = fold_c ? (p_c + lp_z_half) : p_c;
                neg_d        = fold_c;
                cordic_x_d   = gp_xy_width'(gp_x_init);
                cordic_y_d   = '0;
                acc_d        = acc_q + bus.i_fcw;
                cnt_d        = '0;
                cordic_ena_d = 1'b1;
                state_d      = RUN;
`ifdef SGEN_PHASE_DITHER_EN
                lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif
            end
            RUN: begin
                if (cnt_q == lp_cnt_width'(gp_nr_iter)) begin
                    cordic_ena_d = 1'b0;
                    cos_d        = neg_q ? neg_sat(bus.i_cordic_x) : bus.i_cordic_x;
                    sin_d        = neg_q ? neg_sat(bus.i_cordic_y) : bus.i_cordic_y;
                    valid_d      = 1'b1;
                    state_d      = OUT;
                end else begin
                    cnt_d = cnt_q + lp_cnt_width'(1);
                end
            end
            OUT: begin
                if (bus.i_ready) begin
                    valid_d = 1'b0;
                    state_d = bus.i_ena ? ISSUE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            neg_q        <= 1'b0;
            cordic_ena_q <= 1'b0;
            cordic_x_q   <= '0;
            cordic_y_q   <= '0;
            cordic_z_q   <= '0;
            cos_q        <= '0;
            sin_q        <= '0;
            valid_q      <= 1'b0;
`ifdef SGEN_PHASE_DITHER_EN
            lfsr_q       <= 16'hACE1;
`endif
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            neg_q        <= neg_d;
            cordic_ena_q <= cordic_ena_d;
            cordic_x_q   <= cordic_x_d;
            cordic_y_q   <= cordic_y_d;
            cordic_z_q   <= cordic_z_d;
            cos_q        <= cos_d;
            sin_q        <= sin_d;
            valid_q      <= valid_d;
`ifdef SGEN_PHASE_DITHER_EN
            lfsr_q       <= lfsr_d;
`endif
        end
    end

    assign bus.o_cordic_ena = cordic_ena_q;
    assign bus.o_cordic_x   = cordic_x_q;
    assign bus.o_cordic_y   = cordic_y_q;
    assign bus.o_cordic_z   = cordic_z_q;
    assign bus.o_cos        = cos_q;
    assign bus.o_sin        = sin_q;
    assign bus.o_valid      = valid_q;
endmodule

// File: tb/tb_sgen_phase_ctrl.sv
// Directed bench for sgen_phase_ctrl with a behavioural rotation-mode CORDIC core model.
module tb_sgen_phase_ctrl;
    localparam int unsigned PW = 16;
    localparam int unsigned ZW = 8;
    localparam int unsigned XW = 8;
    localparam int unsigned NI = 16;
    localparam int unsigned OW = 2 + 4 * XW + ZW;

    localparam int lp_atan [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                                    41, 20, 10, 5, 3, 1, 1, 0};

    logic i_clk;
    logic i_rst;
    int   checks = 0;
    int   errors = 0;

    logic          ovr;
    logic [XW-1:0] ovr_x, ovr_y;

    sgen_phase_ctrl_if #(.gp_phase_width(PW), .gp_z_width(ZW), .gp_xy_width(XW)) bus ();

    sgen_phase_ctrl #(
        .gp_phase_width(PW), .gp_z_width(ZW), .gp_xy_width(XW),
        .gp_nr_iter(NI), .gp_x_init(77)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Rotation-mode CORDIC, angle in 16-bit binary radians internally, 8 fractional bits on x/y.
    function automatic logic [2*XW-1:0] cordic_model(input logic [XW-1:0] x0, input logic [XW-1:0] y0,
                                                     input logic [ZW-1:0] z0);
        int x, y, z, xn;
        x = int'($signed(x0)) * 256;
        y = int'($signed(y0)) * 256;
        z = int'($signed(z0)) * 256;
        for (int i = 0; i < 16; i++) begin
            if (z >= 0) begin
                xn = x - (y >>> i); y = y + (x >>> i); x = xn; z = z - lp_atan[i];
            end else begin
                xn = x + (y >>> i); y = y - (x >>> i); x = xn; z = z + lp_atan[i];
            end
        end
        x = (x + 128) >>> 8;
        y = (y + 128) >>> 8;
        if (x > 127) x = 127;
        if (x < -128) x = -128;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return {XW'(x), XW'(y)};
    endfunction

    assign {bus.i_cordic_x, bus.i_cordic_y} = ovr ? {ovr_x, ovr_y}
                                                  : cordic_model(bus.o_cordic_x, bus.o_cordic_y, bus.o_cordic_z);

    function automatic logic [OW-1:0] all_outs();
        return {bus.o_cordic_ena, bus.o_cordic_x, bus.o_cordic_y, bus.o_cordic_z,
                bus.o_cos, bus.o_sin, bus.o_valid};
    endfunction

    function automatic bit near(input logic [XW-1:0] v, input int e);
        int d;
        d = int'($signed(v)) - e;
        return (d <= 2) && (d >= -2);
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Runs until the next sample is delivered; captures the issued angle/seeds and the result.
    task automatic run_sample(output logic [ZW-1:0] z, output logic [XW-1:0] sx, output logic [XW-1:0] sy,
                              output logic [XW-1:0] c, output logic [XW-1:0] s,
                              output int edges, output int ena_cycles, output bit ok);
        bit seen;
        seen = 0; ok = 0; edges = 0; ena_cycles = 0;
        z = '0; sx = '0; sy = '0; c = '0; s = '0;
        while (edges < 200 && !ok) begin
            tick();
            edges++;
            if (bus.o_cordic_ena) begin
                ena_cycles++;
                if (!seen) begin
                    seen = 1; z = bus.o_cordic_z; sx = bus.o_cordic_x; sy = bus.o_cordic_y;
                end
            end
            if (seen && bus.o_valid) begin
                ok = 1; c = bus.o_cos; s = bus.o_sin;
            end
        end
    endtask

    task automatic test_reset();
        bit bad;
        i_rst = 1'b1;
        bus.i_ena = 1'($urandom); bus.i_fcw = PW'($urandom); bus.i_ready = 1'($urandom);
        repeat (3) tick();
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        i_rst = 1'b0; bus.i_ena = 1'b0;
        bad = 0;
        repeat (20) begin
            tick();
            if (all_outs() !== '0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL idle_outputs: got %h expected 0", all_outs());
        end
    endtask

    task automatic test_latency();
        int first_valid, ena_cnt;
        logic [ZW-1:0] z1;
        logic [XW-1:0] x1, y1;
        first_valid = 0; ena_cnt = 0; z1 = '1; x1 = '0; y1 = '1;
        bus.i_fcw = 16'h4000; bus.i_ready = 1'b1; bus.i_ena = 1'b1;
        for (int e = 1; e <= 19; e++) begin
            tick();
            if (bus.o_cordic_ena) ena_cnt++;
            if (e == 2) begin z1 = bus.o_cordic_z; x1 = bus.o_cordic_x; y1 = bus.o_cordic_y; end
            if (bus.o_valid && first_valid == 0) first_valid = e;
        end
        checks++;
        if (first_valid !== 19) begin
            errors++; $display("FAIL latency_valid_edge: got %0d expected 19", first_valid);
        end
        checks++;
        if (ena_cnt !== 17) begin
            errors++; $display("FAIL latency_ena_cycles: got %0d expected 17", ena_cnt);
        end
        checks++;
        if (z1 !== 8'h00 || x1 !== 8'd77 || y1 !== 8'd0) begin
            errors++; $display("FAIL first_issue: got z=%h x=%0d y=%0d expected z=00 x=77 y=0", z1, x1, y1);
        end
        checks++;
        if (!near(bus.o_cos, 127) || !near(bus.o_sin, 0)) begin
            errors++; $display("FAIL first_sample: got cos=%0d sin=%0d expected 127,0 +-2",
                               $signed(bus.o_cos), $signed(bus.o_sin));
        end
    endtask

    task automatic test_back_to_back();
        logic [ZW-1:0] exp_z [4] = '{8'hC0, 8'h00, 8'hC0, 8'h00};
        int            exp_c [4] = '{0, -127, 0, 127};
        int            exp_s [4] = '{127, 0, -127, 0};
        logic [ZW-1:0] z;
        logic [XW-1:0] sx, sy, c, s;
        int edges, ena_cycles;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            run_sample(z, sx, sy, c, s, edges, ena_cycles, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL b2b_timeout[%0d]: got no sample expected one", i);
            end
            checks++;
            if (z !== exp_z[i] || sx !== 8'd77 || sy !== 8'd0) begin
                errors++; $display("FAIL b2b_issue[%0d]: got z=%h x=%0d y=%0d expected z=%h x=77 y=0",
                                   i, z, sx, sy, exp_z[i]);
            end
            checks++;
            if (!near(c, exp_c[i]) || !near(s, exp_s[i])) begin
                errors++; $display("FAIL b2b_sample[%0d]: got %0d,%0d expected %0d,%0d +-2",
                                   i, $signed(c), $signed(s), exp_c[i], exp_s[i]);
            end
            checks++;
            if (edges !== 19 || ena_cycles !== 17) begin
                errors++; $display("FAIL b2b_period[%0d]: got %0d edges %0d ena expected 19 edges 17 ena",
                                   i, edges, ena_cycles);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [XW-1:0] c_hold, s_hold, sx, sy, c, s;
        logic [ZW-1:0] z;
        int edges, ena_cycles;
        bit ok, bad;
        bus.i_ready = 1'b0;
        bus.i_fcw = 16'h1000;
        c_hold = bus.o_cos; s_hold = bus.o_sin;
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.o_valid !== 1'b1 || bus.o_cos !== c_hold || bus.o_sin !== s_hold || bus.o_cordic_ena !== 1'b0)
                bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL stall_hold: got valid=%b ena=%b cos=%0d sin=%0d expected 1 0 %0d %0d",
                               bus.o_valid, bus.o_cordic_ena, $signed(bus.o_cos), $signed(bus.o_sin),
                               $signed(c_hold), $signed(s_hold));
        end
        bus.i_ready = 1'b1;
        tick();
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_cordic_ena !== 1'b0) begin
            errors++; $display("FAIL release_edge: got valid=%b ena=%b expected 0 0", bus.o_valid, bus.o_cordic_ena);
        end
        tick();
        checks++;
        if (bus.o_cordic_ena !== 1'b1 || bus.o_cordic_z !== 8'hC0) begin
            errors++; $display("FAIL release_issue: got ena=%b z=%h expected 1 c0", bus.o_cordic_ena, bus.o_cordic_z);
        end
        run_sample(z, sx, sy, c, s, edges, ena_cycles, ok);
        checks++;
        if (!ok || !near(c, 0) || !near(s, 127)) begin
            errors++; $display("FAIL stall_sample: got ok=%b %0d,%0d expected 0,127 +-2", ok, $signed(c), $signed(s));
        end
        run_sample(z, sx, sy, c, s, edges, ena_cycles, ok);
        checks++;
        if (!ok || z !== 8'hD0 || !near(c, -49) || !near(s, 117)) begin
            errors++; $display("FAIL new_fcw_sample: got ok=%b z=%h %0d,%0d expected d0 -49,117 +-2",
                               ok, z, $signed(c), $signed(s));
        end
    endtask

    task automatic test_saturation();
        logic [XW-1:0] sx, sy, c, s;
        logic [ZW-1:0] z;
        int edges, ena_cycles;
        bit ok;
        i_rst = 1'b1;
        tick();
        bus.i_fcw = 16'h8000; ovr = 1'b1; ovr_x = 8'h80; ovr_y = 8'h80;
        i_rst = 1'b0;
        run_sample(z, sx, sy, c, s, edges, ena_cycles, ok);
        checks++;
        if (!ok || z !== 8'h00 || c !== 8'h80 || s !== 8'h80) begin
            errors++; $display("FAIL sat_no_fold: got ok=%b z=%h cos=%h sin=%h expected 00 80 80", ok, z, c, s);
        end
        run_sample(z, sx, sy, c, s, edges, ena_cycles, ok);
        checks++;
        if (!ok || z !== 8'h00 || c !== 8'h7F || s !== 8'h7F) begin
            errors++; $display("FAIL sat_fold: got ok=%b z=%h cos=%h sin=%h expected 00 7f 7f", ok, z, c, s);
        end
        ovr = 1'b0;
    endtask

    task automatic test_midrun_reset();
        logic [XW-1:0] sx, sy, c, s;
        logic [ZW-1:0] z;
        int edges, ena_cycles, n;
        bit ok;
        i_rst = 1'b1;
        tick();
        bus.i_fcw = 16'h2000;
        i_rst = 1'b0;
        run_sample(z, sx, sy, c, s, edges, ena_cycles, ok);
        n = 0;
        while (!bus.o_cordic_ena && n < 10) begin tick(); n++; end
        checks++;
        if (bus.o_cordic_ena !== 1'b1 || bus.o_cordic_z !== 8'h20) begin
            errors++; $display("FAIL second_issue: got ena=%b z=%h expected 1 20", bus.o_cordic_ena, bus.o_cordic_z);
        end
        repeat (5) tick();
        #2;
        i_rst = 1'b1;
        #1;
        checks++;
        if (all_outs() !== '0) begin
            errors++; $display("FAIL midrun_reset_outputs: got %h expected 0", all_outs());
        end
        tick();
        i_rst = 1'b0;
        run_sample(z, sx, sy, c, s, edges, ena_cycles, ok);
        checks++;
        if (!ok || z !== 8'h00 || edges !== 19 || !near(c, 127) || !near(s, 0)) begin
            errors++; $display("FAIL post_reset_sample: got ok=%b z=%h edges=%0d %0d,%0d expected 00 19 127,0",
                               ok, z, edges, $signed(c), $signed(s));
        end
    endtask

    task automatic test_ena_drop();
        logic [XW-1:0] sx, sy, c, s;
        logic [ZW-1:0] z;
        int edges, ena_cycles, n;
        bit ok, bad;
        n = 0;
        while (!bus.o_cordic_ena && n < 10) begin tick(); n++; end
        bus.i_ena = 1'b0;
        run_sample(z, sx, sy, c, s, edges, ena_cycles, ok);
        checks++;
        if (!ok || z !== 8'h20 || !near(c, 90) || !near(s, 90)) begin
            errors++; $display("FAIL drop_sample: got ok=%b z=%h %0d,%0d expected 20 90,90 +-2",
                               ok, z, $signed(c), $signed(s));
        end
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.o_cordic_ena !== 1'b0 || bus.o_valid !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL drop_idle: got ena=%b valid=%b expected 0 0", bus.o_cordic_ena, bus.o_valid);
        end
        bus.i_ena = 1'b1;
        run_sample(z, sx, sy, c, s, edges, ena_cycles, ok);
        checks++;
        if (!ok || z !== 8'hC0 || edges !== 19 || !near(c, 0) || !near(s, 127)) begin
            errors++; $display("FAIL resume_sample: got ok=%b z=%h edges=%0d %0d,%0d expected c0 19 0,127",
                               ok, z, edges, $signed(c), $signed(s));
        end
    endtask

    initial begin
        ovr = 1'b0; ovr_x = '0; ovr_y = '0;
        i_rst = 1'b1; bus.i_ena = 1'b0; bus.i_fcw = '0; bus.i_ready = 1'b0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_saturation();
        test_midrun_reset();
        test_ena_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
